// File: rtl/pc_fetch_sequencer.sv
// Program-counter owner and instruction fetch front end: issues one memory
// request at a time, holds the returned instruction and computes the next PC.
module pc_fetch_sequencer #(
  parameter int PC_WIDTH    = 64,
  parameter int INSTR_WIDTH = 32
) (
  input  logic                   CLK,
  input  logic                   Reset,
  input  logic [PC_WIDTH-1:0]    StartPC,
  output logic                   IMemReq,
  output logic [PC_WIDTH-1:0]    IMemAddr,
  input  logic                   IMemReady,
  input  logic                   IMemValid,
  input  logic [INSTR_WIDTH-1:0] IMemData,
  output logic                   InstrValid,
  output logic [INSTR_WIDTH-1:0] InstrOut,
  output logic [PC_WIDTH-1:0]    CurrentPC,
  input  logic                   InstrAccept,
  input  logic                   Branch,
  input  logic                   ALUZero,
  input  logic                   Uncondbranch,
  input  logic [PC_WIDTH-1:0]    SignExtImm64,
  input  logic                   Flush,
  input  logic [PC_WIDTH-1:0]    FlushPC
);

  typedef enum logic [1:0] {
    S_FETCH = 2'd0,
    S_WAIT  = 2'd1,
    S_HOLD  = 2'd2
  } state_t;

  state_t                 r_state, w_stateNext;
  logic [PC_WIDTH-1:0]    r_pc, w_pcNext;
  logic [INSTR_WIDTH-1:0] r_instr, w_instrNext;
  logic                   r_valid, w_validNext;
  logic                   r_discard, w_discardNext;

  logic [PC_WIDTH-1:0]    w_branchOffset;
  logic [PC_WIDTH-1:0]    w_pcSeq;
  logic [PC_WIDTH-1:0]    w_pcBranch;
  logic                   w_taken;
  logic                   w_unusedImmTop;

  // Word offset becomes a byte offset; the two bits shifted out are lost.
  assign w_branchOffset = {SignExtImm64[PC_WIDTH-3:0], 2'b00};
  assign w_unusedImmTop = ^SignExtImm64[PC_WIDTH-1:PC_WIDTH-2];
  assign w_pcSeq        = r_pc + PC_WIDTH'(4);
  assign w_pcBranch     = r_pc + w_branchOffset;
  assign w_taken        = (Branch & ALUZero) | Uncondbranch;

  assign IMemReq    = (r_state == S_FETCH) & ~Reset;
  assign IMemAddr   = r_pc;
  assign CurrentPC  = r_pc;
  assign InstrValid = r_valid;
  assign InstrOut   = r_instr;

  always_ff @(posedge CLK) begin
    if (Reset) begin
      r_state   <= S_FETCH;
      r_pc      <= StartPC;
      r_instr   <= '0;
      r_valid   <= 1'b0;
      r_discard <= 1'b0;
    end else begin
      r_state   <= w_stateNext;
      r_pc      <= w_pcNext;
      r_instr   <= w_instrNext;
      r_valid   <= w_validNext;
      r_discard <= w_discardNext;
    end
  end

  // Flush outranks every other event; an accepted-but-flushed request is
  // tracked by Discard so its response is swallowed rather than held.
  always_comb begin
    w_stateNext   = r_state;
    w_pcNext      = r_pc;
    w_instrNext   = r_instr;
    w_validNext   = r_valid;
    w_discardNext = r_discard;

    unique case (r_state)
      S_FETCH: begin
        if (Flush) begin
          w_pcNext = FlushPC;
          if (IMemReady) begin
            w_stateNext   = S_WAIT;
            w_discardNext = 1'b1;
          end
        end else if (IMemReady) begin
          w_stateNext = S_WAIT;
        end
      end
      S_WAIT: begin
        if (Flush) begin
          w_pcNext = FlushPC;
          if (IMemValid) begin
            w_stateNext   = S_FETCH;
            w_discardNext = 1'b0;
          end else begin
            w_discardNext = 1'b1;
          end
        end else if (IMemValid) begin
          if (r_discard) begin
            w_stateNext   = S_FETCH;
            w_discardNext = 1'b0;
          end else begin
            w_instrNext = IMemData;
            w_validNext = 1'b1;
            w_stateNext = S_HOLD;
          end
        end
      end
      S_HOLD: begin
        if (Flush) begin
          w_pcNext    = FlushPC;
          w_validNext = 1'b0;
          w_stateNext = S_FETCH;
        end else if (InstrAccept) begin
          w_pcNext    = w_taken ? w_pcBranch : w_pcSeq;
          w_validNext = 1'b0;
          w_stateNext = S_FETCH;
        end
      end
      default: begin
        w_stateNext   = S_FETCH;
        w_validNext   = 1'b0;
        w_discardNext = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_pc_fetch_sequencer.sv
// Scoreboard bench for pc_fetch_sequencer: fetched data is queued when the
// memory model responds and popped when the held instruction is checked.
module tb_pc_fetch_sequencer;

  logic        CLK = 1'b0;
  logic        Reset = 1'b1;
  logic [63:0] StartPC = 64'h1000;
  logic        IMemReq;
  logic [63:0] IMemAddr;
  logic        IMemReady = 1'b0;
  logic        IMemValid = 1'b0;
  logic [31:0] IMemData = 32'h0;
  logic        InstrValid;
  logic [31:0] InstrOut;
  logic [63:0] CurrentPC;
  logic        InstrAccept = 1'b0;
  logic        Branch = 1'b0;
  logic        ALUZero = 1'b0;
  logic        Uncondbranch = 1'b0;
  logic [63:0] SignExtImm64 = 64'h0;
  logic        Flush = 1'b0;
  logic [63:0] FlushPC = 64'h0;

  int total = 0;
  int bad = 0;
  logic [31:0] sbQ[$];

  pc_fetch_sequencer #(.PC_WIDTH(64), .INSTR_WIDTH(32)) dut (
    .CLK(CLK), .Reset(Reset), .StartPC(StartPC),
    .IMemReq(IMemReq), .IMemAddr(IMemAddr), .IMemReady(IMemReady),
    .IMemValid(IMemValid), .IMemData(IMemData),
    .InstrValid(InstrValid), .InstrOut(InstrOut), .CurrentPC(CurrentPC),
    .InstrAccept(InstrAccept), .Branch(Branch), .ALUZero(ALUZero),
    .Uncondbranch(Uncondbranch), .SignExtImm64(SignExtImm64),
    .Flush(Flush), .FlushPC(FlushPC)
  );

  always #5 CLK = ~CLK;

  task automatic cycle();
    @(posedge CLK);
    #1;
  endtask

  // Zero-wait memory: accept the request, respond the next cycle, queue the data.
  task automatic serveFetch(input logic [31:0] data, output logic reqSeen,
                            output logic [63:0] addrSeen);
    reqSeen   = IMemReq;
    addrSeen  = IMemAddr;
    IMemReady = 1'b1;
    cycle();
    IMemReady = 1'b0;
    IMemValid = 1'b1;
    IMemData  = data;
    sbQ.push_back(data);
    cycle();
    IMemValid = 1'b0;
  endtask

  task automatic acceptDrive(input logic b, input logic z, input logic u,
                             input logic [63:0] imm);
    InstrAccept  = 1'b1;
    Branch       = b;
    ALUZero      = z;
    Uncondbranch = u;
    SignExtImm64 = imm;
    cycle();
    InstrAccept  = 1'b0;
    Branch       = 1'b0;
    ALUZero      = 1'b0;
    Uncondbranch = 1'b0;
    SignExtImm64 = 64'h0;
  endtask

  task automatic flushTo(input logic [63:0] pc);
    Flush   = 1'b1;
    FlushPC = pc;
    cycle();
    Flush   = 1'b0;
  endtask

  task automatic test_reset();
    Reset   = 1'b1;
    StartPC = 64'h1000;
    cycle();
    cycle();
    total++;
    if (IMemReq !== 1'b0) begin
      bad++;
      $display("[TB] FAIL reset_req: got %b want 0", IMemReq);
    end
    Reset = 1'b0;
    #1;
    total++;
    if (IMemReq !== 1'b1 || IMemAddr !== 64'h1000 || InstrValid !== 1'b0 ||
        CurrentPC !== 64'h1000) begin
      bad++;
      $display("[TB] FAIL reset_release: req=%b addr=%h vld=%b want 1 1000 0",
               IMemReq, IMemAddr, InstrValid);
    end
  endtask

  task automatic test_sequential();
    logic        req;
    logic [63:0] addr;
    logic [31:0] exp;
    for (int i = 0; i < 3; i++) begin
      serveFetch(32'hA000_0000 + 32'(i), req, addr);
      exp = sbQ.pop_front();
      total++;
      if (req !== 1'b1 || addr !== 64'h1000 + 64'(4 * i)) begin
        bad++;
        $display("[TB] FAIL seq_addr%0d: req=%b addr=%h want %h", i, req, addr,
                 64'h1000 + 64'(4 * i));
      end
      total++;
      if (InstrValid !== 1'b1 || InstrOut !== exp || CurrentPC !== addr) begin
        bad++;
        $display("[TB] FAIL seq_data%0d: vld=%b instr=%h want %h", i, InstrValid,
                 InstrOut, exp);
      end
      acceptDrive(1'b0, 1'b0, 1'b0, 64'h0);
      total++;
      if (InstrValid !== 1'b0) begin
        bad++;
        $display("[TB] FAIL seq_drop%0d: vld=%b want 0", i, InstrValid);
      end
    end
  endtask

  task automatic test_branches();
    logic        req;
    logic [63:0] addr;
    logic [63:0] startPcs[5] = '{64'h1000, 64'h1000, 64'h1000, 64'h1000,
                                 64'hFFFF_FFFF_FFFF_FFFC};
    logic        bv[5] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    logic        zv[5] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    logic        uv[5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    logic [63:0] imms[5] = '{64'hFFFF_FFFF_FFFF_FFFE, 64'hFFFF_FFFF_FFFF_FFFE,
                             64'h10, 64'h10, 64'h0};
    logic [63:0] wants[5] = '{64'h0FF8, 64'h1004, 64'h1040, 64'h1004, 64'h0};
    logic [31:0] exp;
    for (int i = 0; i < 5; i++) begin
      flushTo(startPcs[i]);
      serveFetch(32'hB000_0000 + 32'(i), req, addr);
      exp = sbQ.pop_front();
      total++;
      if (addr !== startPcs[i] || InstrOut !== exp) begin
        bad++;
        $display("[TB] FAIL br_fetch%0d: addr=%h instr=%h want %h %h", i, addr,
                 InstrOut, startPcs[i], exp);
      end
      acceptDrive(bv[i], zv[i], uv[i], imms[i]);
      total++;
      if (IMemAddr !== wants[i] || IMemReq !== 1'b1) begin
        bad++;
        $display("[TB] FAIL br_next%0d: addr=%h want %h", i, IMemAddr, wants[i]);
      end
    end
    flushTo(64'h1000);
    serveFetch(32'hB0B0_0000, req, addr);
    void'(sbQ.pop_front());
    acceptDrive(1'b0, 1'b0, 1'b1, 64'h4000_0000_0000_0001);
    total++;
    if (IMemAddr !== 64'h1004) begin
      bad++;
      $display("[TB] FAIL br_shift_trunc: addr=%h want 1004", IMemAddr);
    end
  endtask

  task automatic test_flush_wait();
    logic        req;
    logic [63:0] addr;
    logic [31:0] exp;
    IMemReady = 1'b1;
    cycle();
    IMemReady = 1'b0;
    flushTo(64'h2000);
    total++;
    if (IMemReq !== 1'b0 || IMemAddr !== 64'h2000) begin
      bad++;
      $display("[TB] FAIL fw_redirect: req=%b addr=%h want 0 2000", IMemReq, IMemAddr);
    end
    cycle();
    IMemValid = 1'b1;
    IMemData  = 32'hDEAD_BEEF;
    cycle();
    IMemValid = 1'b0;
    total++;
    if (InstrValid !== 1'b0 || IMemReq !== 1'b1 || IMemAddr !== 64'h2000) begin
      bad++;
      $display("[TB] FAIL fw_drop: vld=%b req=%b addr=%h want 0 1 2000",
               InstrValid, IMemReq, IMemAddr);
    end
    serveFetch(32'hC0DE_0001, req, addr);
    exp = sbQ.pop_front();
    total++;
    if (addr !== 64'h2000 || InstrOut !== exp || InstrValid !== 1'b1) begin
      bad++;
      $display("[TB] FAIL fw_refetch: addr=%h instr=%h want 2000 %h", addr, InstrOut, exp);
    end
    acceptDrive(1'b0, 1'b0, 1'b0, 64'h0);
    IMemReady = 1'b1;
    cycle();
    IMemReady = 1'b0;
    Flush     = 1'b1;
    FlushPC   = 64'h2400;
    IMemValid = 1'b1;
    IMemData  = 32'h1234_5678;
    cycle();
    Flush     = 1'b0;
    IMemValid = 1'b0;
    total++;
    if (InstrValid !== 1'b0 || IMemReq !== 1'b1 || IMemAddr !== 64'h2400) begin
      bad++;
      $display("[TB] FAIL fw_same_cycle: vld=%b req=%b addr=%h want 0 1 2400",
               InstrValid, IMemReq, IMemAddr);
    end
    Flush     = 1'b1;
    FlushPC   = 64'h5000;
    IMemReady = 1'b1;
    cycle();
    Flush     = 1'b0;
    IMemReady = 1'b0;
    total++;
    if (IMemReq !== 1'b0 || IMemAddr !== 64'h5000) begin
      bad++;
      $display("[TB] FAIL ff_accepted: req=%b addr=%h want 0 5000", IMemReq, IMemAddr);
    end
    IMemValid = 1'b1;
    IMemData  = 32'hBAD0_BAD0;
    cycle();
    IMemValid = 1'b0;
    total++;
    if (InstrValid !== 1'b0 || IMemReq !== 1'b1 || IMemAddr !== 64'h5000) begin
      bad++;
      $display("[TB] FAIL ff_drop: vld=%b req=%b addr=%h want 0 1 5000",
               InstrValid, IMemReq, IMemAddr);
    end
  endtask

  task automatic test_flush_hold();
    logic        req;
    logic [63:0] addr;
    logic [31:0] exp;
    serveFetch(32'hD000_0001, req, addr);
    void'(sbQ.pop_front());
    Flush        = 1'b1;
    FlushPC      = 64'h3000;
    InstrAccept  = 1'b1;
    Uncondbranch = 1'b1;
    SignExtImm64 = 64'h10;
    cycle();
    Flush        = 1'b0;
    InstrAccept  = 1'b0;
    Uncondbranch = 1'b0;
    SignExtImm64 = 64'h0;
    total++;
    if (InstrValid !== 1'b0 || IMemAddr !== 64'h3000) begin
      bad++;
      $display("[TB] FAIL fh_redirect: vld=%b addr=%h want 0 3000", InstrValid, IMemAddr);
    end
    for (int i = 0; i < 3; i++) begin
      cycle();
      total++;
      if (IMemReq !== 1'b1 || IMemAddr !== 64'h3000) begin
        bad++;
        $display("[TB] FAIL fh_waitstate%0d: req=%b addr=%h want 1 3000", i,
                 IMemReq, IMemAddr);
      end
    end
    serveFetch(32'hD000_0002, req, addr);
    exp = sbQ.pop_front();
    total++;
    if (addr !== 64'h3000 || InstrOut !== exp) begin
      bad++;
      $display("[TB] FAIL fh_fetch: addr=%h instr=%h want 3000 %h", addr, InstrOut, exp);
    end
    acceptDrive(1'b0, 1'b0, 1'b0, 64'h0);
  endtask

  task automatic test_stray_valid();
    logic        req;
    logic [63:0] addr;
    logic [31:0] exp;
    IMemValid = 1'b1;
    IMemData  = 32'h1111_1111;
    cycle();
    IMemValid = 1'b0;
    total++;
    if (InstrValid !== 1'b0 || IMemReq !== 1'b1 || IMemAddr !== 64'h3004) begin
      bad++;
      $display("[TB] FAIL sv_fetch: vld=%b req=%b addr=%h want 0 1 3004",
               InstrValid, IMemReq, IMemAddr);
    end
    serveFetch(32'hE000_0001, req, addr);
    exp = sbQ.pop_front();
    IMemValid = 1'b1;
    IMemData  = 32'h2222_2222;
    cycle();
    IMemValid = 1'b0;
    total++;
    if (InstrValid !== 1'b1 || InstrOut !== exp) begin
      bad++;
      $display("[TB] FAIL sv_hold: vld=%b instr=%h want 1 %h", InstrValid, InstrOut, exp);
    end
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_branches();
    test_flush_wait();
    test_flush_hold();
    test_stray_valid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
